// File: rtl/npc_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 size/sign codes and the access legality check used at accept time.
package npc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // True when a load/store request must be rejected: unknown funct3 for its
    // kind, or an address that is not naturally aligned for the access size.
    // Non-memory requests never fault.
    function automatic logic lsu_access_err(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] func3,
        input logic [1:0] off
    );
        logic illegal;
        logic misaligned;
        misaligned = ((func3[1:0] == 2'b01) && off[0]) ||
                     ((func3[1:0] == 2'b10) && (off != 2'b00));
        if (is_load) begin
            illegal = !((func3 == LB) || (func3 == LH) || (func3 == LW) ||
                        (func3 == LBU) || (func3 == LHU));
        end else if (is_store) begin
            illegal = !((func3 == SB) || (func3 == SH) || (func3 == SW));
        end else begin
            illegal = 1'b0;
        end
        return (is_load || is_store) && (illegal || misaligned);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: shifts store data and builds the byte mask
// for the addressed lanes, and extracts/extends load data from a read word.
// Purely combinational; legality is checked before an access reaches here.
module lsu_align
    import npc_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] load_data
);

    logic [31:0] rd_shift;

    // Lane shifting for stores, lane selection plus sign/zero extension for loads
    always_comb begin
        rd_shift   = rdata >> {off, 3'b000};
        lane_wdata = wdata << {off, 3'b000};

        case (func3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase

        case (func3)
            LB:      load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            LBU:     load_data = {24'h000000, rd_shift[7:0]};
            LH:      load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            LHU:     load_data = {16'h0000, rd_shift[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time from the execute stage,
// drives a single-port sram for loads and stores, and hands one result to
// writeback. Non-memory requests pass their ALU result straight through;
// faulting accesses answer immediately with an error and never touch sram.
module lsu
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_func3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd,
    output logic        sram_ren,
    output logic        sram_wen,
    output logic [7:0]  sram_wmask,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  func3_q, func3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        valid_q, valid_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;
    logic [31:0] load_data;
    logic        accept;
    logic        access_err;

    // Lane logic works only from latched request fields, so the sram address,
    // data and mask cannot move while an access is outstanding.
    lsu_align u_align (
        .off        (addr_q[1:0]),
        .func3      (func3_q),
        .wdata      (wdata_q),
        .rdata      (sram_rdata),
        .lane_wdata (lane_wdata),
        .lane_mask  (lane_mask),
        .load_data  (load_data)
    );

    assign accept     = in_valid && in_ready;
    assign access_err = lsu_access_err(in_is_load, in_is_store, in_func3, in_addr[1:0]);

    // Next-state and next-output computation for the request FSM
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    func3_d = in_func3;
                    rd_d    = in_rd;
                    if (access_err) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (in_is_load) begin
                        state_d = S_RD;
                        err_d   = 1'b0;
                        rdata_d = 32'h0;
                    end else if (in_is_store) begin
                        state_d = S_WR;
                        err_d   = 1'b0;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = in_addr;
                    end
                end
            end
            S_RD: begin
                if (sram_valid) begin
                    rdata_d = load_data;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                if (sram_valid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of the next state, so ren/wen are
        // never asserted together and drop in the same cycle RESP starts.
        ren_d   = (state_d == S_RD);
        wen_d   = (state_d == S_WR);
        valid_d = (state_d == S_RESP);
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            func3_q <= 3'b000;
            rd_q    <= 5'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            valid_q <= valid_d;
        end
    end

    // Outputs are forced quiet for the whole time reset is held, including
    // the cycle in which it is first raised.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign sram_ren   = ren_q && !rst;
    assign sram_wen   = wen_q && !rst;
    assign sram_wmask = (wen_q && !rst) ? {4'b0000, lane_mask} : 8'h00;
    assign sram_addr  = {addr_q[31:2], 2'b00};
    assign sram_wdata = lane_wdata;
    assign out_valid  = valid_q && !rst;
    assign out_rdata  = rst ? 32'h0 : rdata_q;
    assign out_rd     = rst ? 5'd0 : rd_q;
    assign out_err    = err_q && !rst;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed vector table, hand-written multi-cycle corner
// sequences, then randomized traffic checked against a byte-addressed memory
// reference model.
module tb_lsu;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_func3;
    logic        in_is_load;
    logic        in_is_store;
    logic [4:0]  in_rd;
    logic        sram_ren;
    logic        sram_wen;
    logic [7:0]  sram_wmask;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;

    lsu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_func3    (in_func3),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_rd       (in_rd),
        .sram_ren    (sram_ren),
        .sram_wen    (sram_wen),
        .sram_wmask  (sram_wmask),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_valid  (sram_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_rd      (out_rd),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- sram model ----------------
    logic [31:0] sram_mem [0:15];
    logic [7:0]  ref_mem  [0:63];
    int          rd_cnt;
    int          rd_lat = 1;
    logic        wr_ok = 1'b1;
    logic        use_mem = 1'b0;
    logic        load_mem = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;
    logic        rd_valid;

    assign rd_valid   = sram_ren && (rd_cnt >= rd_lat);
    assign sram_valid = rd_valid || (sram_wen && wr_ok);
    assign sram_rdata = use_mem ? sram_mem[sram_addr[5:2]] : fixed_rdata;

    always @(posedge clk) begin
        if (rst || !sram_ren || rd_valid) rd_cnt <= 0;
        else                               rd_cnt <= rd_cnt + 1;
        if (load_mem) begin
            for (int i = 0; i < 16; i++)
                sram_mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else if (sram_wen && wr_ok) begin
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Results of the last transaction
    logic [31:0] r_rdata, r_saddr, r_swdata;
    logic [7:0]  r_smask;
    logic        r_err, r_both, r_stab_bad, r_hold_bad, r_idle, r_timeout;
    logic [4:0]  r_rd;
    int          r_lat, r_ren, r_wen;
    logic        prev_en;
    logic [31:0] prev_addr, prev_wd;
    logic [7:0]  prev_mask;

    task automatic sample_bus();
        if (sram_ren) r_ren++;
        if (sram_wen) begin
            r_wen++;
            r_swdata = sram_wdata;
            r_smask  = sram_wmask;
        end
        if (sram_ren || sram_wen) r_saddr = sram_addr;
        if (sram_ren && sram_wen) r_both = 1'b1;
        if ((sram_ren || sram_wen) && prev_en &&
            (sram_addr !== prev_addr || sram_wdata !== prev_wd || sram_wmask !== prev_mask))
            r_stab_bad = 1'b1;
        prev_en   = sram_ren || sram_wen;
        prev_addr = sram_addr;
        prev_wd   = sram_wdata;
        prev_mask = sram_wmask;
    endtask

    // Issue one request, wait for its response, hold it 'hold' cycles, retire it.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input int hold);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin step(); guard++; end
        r_ren = 0; r_wen = 0; r_both = 0; r_stab_bad = 0; r_hold_bad = 0;
        r_saddr = 32'h0; r_swdata = 32'h0; r_smask = 8'h0; prev_en = 0;
        prev_addr = 32'h0; prev_wd = 32'h0; prev_mask = 8'h0;
        r_timeout = 1'b0;
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_func3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd; out_ready = 1'b0;
        step();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        r_lat = 1;
        while (!out_valid && r_lat < 20) begin
            sample_bus();
            out_ready = 1'($urandom_range(0, 1));
            step();
            r_lat++;
        end
        out_ready = 1'b0;
        sample_bus();
        if (!out_valid) r_timeout = 1'b1;
        r_rdata = out_rdata; r_err = out_err; r_rd = out_rd;
        for (int i = 0; i < hold; i++) begin
            step();
            if (out_valid !== 1'b1 || out_rdata !== r_rdata || out_err !== r_err ||
                out_rd !== r_rd || in_ready !== 1'b0)
                r_hold_bad = 1'b1;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        r_idle = !out_valid && in_ready;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_swdata;
        logic [7:0]  exp_smask;
    } vec_t;

    vec_t vecs [20];

    // Reference-model state for random traffic
    logic [31:0] e_rdata, e_mask;
    logic        e_err;
    int          e_lat, size, off;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_func3 = 3'b000;
        in_is_load = 1'b0; in_is_store = 1'b0; in_rd = 5'd0; out_ready = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, LW,  32'h80000004, 32'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, LB,  32'h80000003, 32'h0, 32'h80FF1234, 3, 32'hFFFFFF80, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, LBU, 32'h80000003, 32'h0, 32'h80FF1234, 3, 32'h00000080, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, LHU, 32'h80000002, 32'h0, 32'h80FF1234, 3, 32'h000080FF, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, LH,  32'h80000002, 32'h0, 32'h80FF1234, 3, 32'hFFFF80FF, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, LH,  32'h80000000, 32'h0, 32'h80FF1234, 3, 32'h00001234, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, LB,  32'h80000001, 32'h0, 32'h80FF1234, 3, 32'h00000012, 1'b0, 2, 0, 32'h0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, SH,  32'h80000002, 32'h0000ABCD, 32'h0, 2, 32'h0, 1'b0, 0, 1, 32'hABCD0000, 8'h0C};
        vecs[8]  = '{1'b0, 1'b1, SB,  32'h80000001, 32'h000000A5, 32'h0, 2, 32'h0, 1'b0, 0, 1, 32'h0000A500, 8'h02};
        vecs[9]  = '{1'b0, 1'b1, SW,  32'h80000008, 32'h12345678, 32'h0, 2, 32'h0, 1'b0, 0, 1, 32'h12345678, 8'h0F};
        vecs[10] = '{1'b1, 1'b0, LW,  32'h80000001, 32'h0, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, LH,  32'h80000003, 32'h0, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, SW,  32'h80000002, 32'h5555AAAA, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h80000000, 32'h11111111, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 32'h0, 1, 32'h12345678, 1'b0, 0, 0, 32'h0, 8'h00};
        vecs[16] = '{1'b1, 1'b0, LHU, 32'h80000001, 32'h0, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[17] = '{1'b0, 1'b1, SB,  32'h80000003, 32'hFFFFFF5A, 32'h0, 2, 32'h0, 1'b0, 0, 1, 32'h5A000000, 8'h08};
        vecs[18] = '{1'b1, 1'b0, 3'b110, 32'h80000000, 32'h0, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};
        vecs[19] = '{1'b0, 1'b1, 3'b111, 32'h80000004, 32'h22222222, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 8'h00};

        // ---- reset state, with a request waved at the idle unit ----
        in_valid = 1'b1; in_is_load = 1'b1; in_func3 = LW; in_addr = 32'h80000000;
        step(); step(); step();
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_ren_wen", {30'h0, sram_ren, sram_wen}, 32'h0);
        check("rst_wmask", {24'h0, sram_wmask}, 32'h0);
        check("rst_out_fields", {26'h0, out_err, out_rd}, 32'h0);
        check("rst_out_rdata", out_rdata, 32'h0);
        in_valid = 1'b0; in_is_load = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        $display("seq reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // ---- directed table ----
        use_mem = 1'b0; rd_lat = 1;
        for (int i = 0; i < 20; i++) begin
            fixed_rdata = vecs[i].rdata;
            run_txn(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    5'(i + 1), (i == 0) ? 5 : (i % 3));
            $display("vec %0d: ld=%0b st=%0b f3=%0d addr=%08h lat=%0d rdata=%08h err=%0b ren=%0d wen=%0d",
                     i, vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, r_lat, r_rdata, r_err, r_ren, r_wen);
            check($sformatf("vec%0d_timeout", i), {31'h0, r_timeout}, 32'h0);
            check($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_rd", i), {27'h0, r_rd}, 32'(i + 1));
            check($sformatf("vec%0d_ren_cycles", i), 32'(r_ren), 32'(vecs[i].exp_ren));
            check($sformatf("vec%0d_wen_cycles", i), 32'(r_wen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_ren_wen_overlap", i), {31'h0, r_both}, 32'h0);
            check($sformatf("vec%0d_bus_stable", i), {31'h0, r_stab_bad}, 32'h0);
            check($sformatf("vec%0d_resp_stable", i), {31'h0, r_hold_bad}, 32'h0);
            check($sformatf("vec%0d_back_to_idle", i), {31'h0, r_idle}, 32'h1);
            if (vecs[i].exp_ren + vecs[i].exp_wen > 0)
                check($sformatf("vec%0d_sram_addr", i), r_saddr, vecs[i].addr & 32'hFFFFFFFC);
            if (vecs[i].exp_wen > 0) begin
                check($sformatf("vec%0d_sram_wdata", i), r_swdata, vecs[i].exp_swdata);
                check($sformatf("vec%0d_sram_wmask", i), {24'h0, r_smask}, {24'h0, vecs[i].exp_smask});
            end
        end

        // ---- no accept in RESP even with out_ready and in_valid high ----
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_func3 = 3'b000;
        in_addr = 32'hCAFE0001; in_rd = 5'd3;
        step();
        check("b2b_first_resp", {31'h0, out_valid}, 32'h1);
        check("b2b_first_rdata", out_rdata, 32'hCAFE0001);
        in_addr = 32'hCAFE0002; in_rd = 5'd4; out_ready = 1'b1;
        step();
        check("b2b_idle_gap_valid", {31'h0, out_valid}, 32'h0);
        check("b2b_idle_gap_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("b2b_second_resp", {31'h0, out_valid}, 32'h1);
        check("b2b_second_rdata", out_rdata, 32'hCAFE0002);
        check("b2b_second_rd", {27'h0, out_rd}, 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("seq back_to_back: in_ready=%0b", in_ready);

        // ---- reset in the cycle sram_valid rises during RD ----
        fixed_rdata = 32'h01020304; rd_lat = 1;
        in_valid = 1'b1; in_is_load = 1'b1; in_func3 = LW; in_addr = 32'h80000000; in_rd = 5'd9;
        step();
        in_valid = 1'b0; in_is_load = 1'b0;
        check("rstrd_ren_t1", {31'h0, sram_ren}, 32'h1);
        step();
        check("rstrd_sram_valid_t2", {31'h0, sram_valid}, 32'h1);
        rst = 1'b1;
        step();
        check("rstrd_out_valid", {31'h0, out_valid}, 32'h0);
        check("rstrd_ren", {31'h0, sram_ren}, 32'h0);
        check("rstrd_in_ready_in_rst", {31'h0, in_ready}, 32'h0);
        check("rstrd_out_rdata", out_rdata, 32'h0);
        check("rstrd_out_rd", {27'h0, out_rd}, 32'h0);
        rst = 1'b0;
        #1;
        check("rstrd_in_ready_after", {31'h0, in_ready}, 32'h1);
        step();
        check("rstrd_no_late_resp", {31'h0, out_valid}, 32'h0);
        $display("seq reset_in_rd: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // ---- store with sram holding off the write ----
        wr_ok = 1'b0;
        in_valid = 1'b1; in_is_store = 1'b1; in_func3 = SW; in_addr = 32'h80000010;
        in_wdata = 32'h11223344; in_rd = 5'd7;
        step();
        in_valid = 1'b0; in_is_store = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_wen_%0d", k), {30'h0, sram_wen, out_valid}, 32'h2);
            step();
        end
        wr_ok = 1'b1;
        #1;
        check("stall_release_valid", {31'h0, sram_valid}, 32'h1);
        step();
        check("stall_resp", {30'h0, out_valid, sram_wen}, 32'h2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("seq store_stall: in_ready=%0b", in_ready);

        // ---- randomized traffic against a byte-level memory model ----
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        load_mem = 1'b1;
        step();
        load_mem = 1'b0;
        use_mem = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int kind, hold;
            logic [2:0]  f3;
            logic [31:0] addr, wd;
            logic [4:0]  rd;
            logic        legal;
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            rd   = 5'($urandom);
            hold = $urandom_range(0, 3);
            rd_lat = $urandom_range(1, 3);
            off  = $urandom_range(0, 63);
            addr = (kind == 2) ? $urandom : 32'h80000000 + 32'(off);

            e_err = 1'b0; e_rdata = 32'h0; e_lat = 1; e_mask = 32'h0;
            size = 1 << f3[1:0];
            if (kind == 0) begin
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
                if (!legal || (off % size) != 0) e_err = 1'b1;
                else begin
                    e_lat = 2 + rd_lat;
                    for (int b = 0; b < size; b++) e_rdata = e_rdata | (32'(ref_mem[off + b]) << (8 * b));
                    if (!f3[2] && size < 4 && e_rdata[8 * size - 1])
                        e_rdata = e_rdata | ~((32'h1 << (8 * size)) - 32'h1);
                end
            end else if (kind == 1) begin
                legal = (f3 <= 3'd2);
                if (!legal || (off % size) != 0) e_err = 1'b1;
                else begin
                    e_lat = 2;
                    e_mask = ((32'h1 << size) - 32'h1) << (off % 4);
                end
            end else begin
                e_rdata = addr;
            end

            run_txn(kind == 0, kind == 1, f3, addr, wd, rd, hold);
            $display("rnd %0d: kind=%0d f3=%0d addr=%08h wdata=%08h lat=%0d rdata=%08h err=%0b",
                     t, kind, f3, addr, wd, r_lat, r_rdata, r_err);
            check($sformatf("rnd%0d_timeout", t), {31'h0, r_timeout}, 32'h0);
            check($sformatf("rnd%0d_latency", t), 32'(r_lat), 32'(e_lat));
            check($sformatf("rnd%0d_err", t), {31'h0, r_err}, {31'h0, e_err});
            check($sformatf("rnd%0d_rdata", t), r_rdata, e_rdata);
            check($sformatf("rnd%0d_rd", t), {27'h0, r_rd}, {27'h0, rd});
            check($sformatf("rnd%0d_overlap_stable", t), {30'h0, r_both, r_stab_bad}, 32'h0);
            check($sformatf("rnd%0d_resp_hold", t), {31'h0, r_hold_bad}, 32'h0);
            check($sformatf("rnd%0d_back_to_idle", t), {31'h0, r_idle}, 32'h1);
            if (e_err || kind == 2)
                check($sformatf("rnd%0d_no_sram", t), 32'(r_ren + r_wen), 32'h0);
            if (kind == 1 && !e_err) begin
                check($sformatf("rnd%0d_wmask", t), {24'h0, r_smask}, e_mask);
                for (int b = 0; b < size; b++) ref_mem[off + b] = wd[8 * b +: 8];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL expose no parameters; all widths are fixed (32-bit address/data, 8-bit write mask).
REQ-002 Ports SHALL be, one per line, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  EXU request valid.
- in_ready  out  1  LSU can accept a request.
- in_addr  in  32  effective address, or ALU result for non-memory ops.
- in_wdata  in  32  store data (rs2).
- in_func3  in  3  RISC-V funct3 (size/sign).
- in_is_load  in  1  request is a load.
- in_is_store  in  1  request is a store (never both with in_is_load).
- in_rd  in  5  destination register tag.
- sram_ren  out  1  read enable to sram.
- sram_wen  out  1  write enable to sram.
- sram_wmask  out  8  byte mask to sram; bits [7:4] always 0.
- sram_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- sram_wdata  out  32  lane-shifted store data.
- sram_rdata  in  32  sram read data.
- sram_valid  in  1  sram completion (read data valid, or write accepted).
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts result.
- out_rdata  out  32  load result (extended), ALU pass-through, or 0.
- out_rd  out  5  latched in_rd.
- out_err  out  1  misaligned access or illegal funct3.

Function
REQ-003 FSM states SHALL be IDLE, RD, WR, RESP; in_ready=1 only in IDLE.
REQ-004 IDLE: on in_valid&in_ready latch addr, wdata, func3, rd, kind; load->RD, store->WR, neither->RESP with out_rdata=in_addr.
REQ-005 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or illegal funct3 (load 011/110/111; store other than 000/001/010) SHALL go IDLE->RESP with out_err=1, out_rdata=0, no sram enable ever asserted.
REQ-006 RD: sram_ren=1 held every cycle in RD; on sram_valid=1 capture extracted data, go RESP; sram_ren SHALL deassert in the RESP cycle.
REQ-007 WR: sram_wen=1 for exactly one cycle; sram_valid (combinational from wen) moves WR->RESP; if sram_valid=0, stay WR with wen held.
REQ-008 RESP: out_valid=1, outputs stable until out_ready=1; then IDLE; out_ready while not RESP ignored.
REQ-009 Latency from accept cycle T: load out_valid at T+3 (ren T+1..T+2, sram_valid T+2); store at T+2; pass-through or error at T+1.
REQ-010 Load extract with off=addr[1:0]: LB/LBU byte rdata[8*off+:8], LH/LHU half rdata[8*off+:16], LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-011 Store: sram_wdata = wdata << 8*off; sram_wmask = SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111, zero-extended to 8 bits.
REQ-012 sram_addr, sram_wdata, sram_wmask SHALL be stable while ren or wen is asserted; sram_ren and sram_wen SHALL never be asserted together.
REQ-013 No request is accepted in RESP, even if out_ready and in_valid are high in the same cycle; the next accept is the cycle after return to IDLE.

Reset
REQ-014 rst=1 at a clock edge SHALL force IDLE from any state, dropping any in-flight access without response.
REQ-015 While in reset: in_ready=0, out_valid=0, sram_ren=0, sram_wen=0, sram_wmask=0, out_err=0, out_rdata=0, out_rd=0.

Structure
REQ-016 Shared package npc_pkg SHALL hold the lsu state enum and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-017 Lane shifting, masking and extension SHALL live in one combinational sub-module lsu_align; the FSM stays in lsu.

Verification
REQ-018 LW addr 0x80000004, sram_rdata 0xDEADBEEF -> ren T+1..T+2, out_valid T+3, out_rdata 0xDEADBEEF, out_err 0.
REQ-019 LB addr 0x80000003, rdata 0x80FF1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x80000002 -> 0x000080FF.
REQ-020 SH addr 0x80000002, wdata 0x0000ABCD -> sram_wdata 0xABCD0000, wmask 0x0C, wen for exactly 1 cycle, out_valid T+2.
REQ-021 LW addr 0x80000001 -> out_valid T+1, out_err 1, out_rdata 0, sram_ren/wen never 1.
REQ-022 out_ready held 0 for 5 cycles in RESP -> out_valid/out_rdata stable, in_ready 0; then out_ready=1 -> IDLE next cycle.
REQ-023 rst=1 in the cycle sram_valid rises during RD -> next cycle IDLE, out_valid 0, sram_ren 0, in_ready 1 after rst drops.
